// File: rtl/dlx_ext_pkg.sv
// Shared definitions for the extended DLX datapath blocks.
package dlx_ext_pkg;

   localparam int unsigned DATA_W = 32;

   // Occupancy counters need one extra bit so that "full" (count == depth) is representable.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO; dout reads as zero while empty.
module fifo_sync
   import dlx_ext_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [WIDTH-1:0]          din,
   input  logic                      pop,
   output logic [WIDTH-1:0]          dout,
   output logic                      empty,
   output logic                      full,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = cnt_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;

   logic w_push_en;
   logic w_pop_en;

   // A push into a full queue is dropped even if a pop happens the same cycle.
   assign w_push_en = push && !full;
   assign w_pop_en  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_en) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
         case ({w_push_en, w_pop_en})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_en) r_mem[r_wr_ptr] <= din;
   end

   assign empty = (r_count == '0);
   assign full  = (r_count == CntW'(DEPTH));
   assign count = r_count;
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/demux_32bit_buf.sv
// Buffered 1:2 demux: steers each input word by in_sel into one of two independent FIFOs.
module demux_32bit_buf
   import dlx_ext_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_sel,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out0_data,
   output logic                      out0_valid,
   input  logic                      out0_ready,
   output logic [cnt_w(DEPTH)-1:0]   out0_count,
   output logic [WIDTH-1:0]          out1_data,
   output logic                      out1_valid,
   input  logic                      out1_ready,
   output logic [cnt_w(DEPTH)-1:0]   out1_count
);

   logic w_full0;
   logic w_full1;
   logic w_empty0;
   logic w_empty1;
   logic w_push0;
   logic w_push1;

   // Ready depends only on the select and registered occupancy, never on the consumer readies.
   assign in_ready = in_sel ? !w_full1 : !w_full0;
   assign w_push0  = in_valid && in_ready && !in_sel;
   assign w_push1  = in_valid && in_ready && in_sel;

   assign out0_valid = !w_empty0;
   assign out1_valid = !w_empty1;

   fifo_sync #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push0),
      .din   (in_data),
      .pop   (out0_ready),
      .dout  (out0_data),
      .empty (w_empty0),
      .full  (w_full0),
      .count (out0_count)
   );

   fifo_sync #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push1),
      .din   (in_data),
      .pop   (out1_ready),
      .dout  (out1_data),
      .empty (w_empty1),
      .full  (w_full1),
      .count (out1_count)
   );

endmodule

// File: tb/tb_demux_32bit_buf.sv
// Self-checking bench for demux_32bit_buf: per-port scoreboards plus scenario tasks.
module tb_demux_32bit_buf;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [CW-1:0]    out0_count;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CW-1:0]    out1_count;

   logic [WIDTH-1:0] exp0[$];
   logic [WIDTH-1:0] exp1[$];
   int n_tests = 0;
   int n_fail  = 0;

   demux_32bit_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_count (out0_count),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_count (out1_count)
   );

   always #5 clk = ~clk;

   // Scoreboard: every word the consumer takes must match the oldest expected word of that port.
   always @(negedge clk) begin
      if (rst === 1'b0 && out0_valid === 1'b1 && out0_ready === 1'b1) begin
         n_tests++;
         if (exp0.size() == 0) begin
            n_fail++;
            $display("FAIL port0_unexpected: got %h, no word expected", out0_data);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp0.pop_front();
            if (out0_data !== e) begin
               n_fail++;
               $display("FAIL port0_data: got %h expected %h", out0_data, e);
            end
         end
      end
      if (rst === 1'b0 && out1_valid === 1'b1 && out1_ready === 1'b1) begin
         n_tests++;
         if (exp1.size() == 0) begin
            n_fail++;
            $display("FAIL port1_unexpected: got %h, no word expected", out1_data);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp1.pop_front();
            if (out1_data !== e) begin
               n_fail++;
               $display("FAIL port1_data: got %h expected %h", out1_data, e);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      n_tests++;
      if ({out0_valid, out1_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_valid: got %b expected 00", {out0_valid, out1_valid});
      end
      n_tests++;
      if (out0_data !== '0 || out1_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h expected 0/0", out0_data, out1_data);
      end
      n_tests++;
      if (out0_count !== '0 || out1_count !== '0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d/%0d expected 0/0", out0_count, out1_count);
      end
      for (int s = 0; s < 2; s++) begin
         in_sel = s[0];
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready sel%0d: got %b expected 1", s, in_ready);
         end
      end
   endtask

   task automatic test_basic();
      out0_ready = 1'b1; out1_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
      exp0.push_back(in_data);
      cyc();
      n_tests++;
      if (out0_valid !== 1'b1 || out0_data !== 32'hDEAD_BEEF || out1_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_port0: got v0=%b d0=%h v1=%b expected v0=1 d0=deadbeef v1=0",
                  out0_valid, out0_data, out1_valid);
      end
      in_sel = 1'b1; in_data = 32'h1234_5678;
      exp1.push_back(in_data);
      cyc();
      n_tests++;
      if (out1_valid !== 1'b1 || out1_data !== 32'h1234_5678 || out0_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_port1: got v1=%b d1=%h v0=%b expected v1=1 d1=12345678 v0=0",
                  out1_valid, out1_data, out0_valid);
      end
      in_valid = 1'b0;
      cyc();
      n_tests++;
      if (out0_count !== '0 || out1_count !== '0) begin
         n_fail++;
         $display("FAIL basic_drain: got %0d/%0d expected 0/0", out0_count, out1_count);
      end
   endtask

   task automatic test_fill();
      out0_ready = 1'b0; out1_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_data = 32'hA000_0000 + i;
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_accept%0d: got %b expected 1", i, in_ready);
         end
         exp0.push_back(in_data);
         cyc();
      end
      in_data = 32'hA000_0002;
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out0_count !== CW'(2)) begin
         n_fail++;
         $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=2",
                  in_ready, out0_count);
      end
      cyc();
      // Queue 0 stalled; port 1 must still flow.
      in_sel = 1'b1; in_data = 32'hB000_0001;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out0_count !== CW'(2)) begin
         n_fail++;
         $display("FAIL fill_other_ready: got ready=%b count0=%0d expected ready=1 count0=2",
                  in_ready, out0_count);
      end
      exp1.push_back(in_data);
      cyc();
      in_valid = 1'b0;
      n_tests++;
      if (out1_valid !== 1'b1 || out1_data !== 32'hB000_0001) begin
         n_fail++;
         $display("FAIL fill_port1: got v=%b d=%h expected v=1 d=b0000001", out1_valid, out1_data);
      end
      out0_ready = 1'b1;
      cyc(); cyc();
      n_tests++;
      if (out0_count !== '0) begin
         n_fail++;
         $display("FAIL fill_drain: got %0d expected 0", out0_count);
      end
   endtask

   task automatic test_full_pop();
      out0_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0;
      in_data = 32'h0000_000A; exp0.push_back(in_data); cyc();
      in_data = 32'h0000_000B; exp0.push_back(in_data); cyc();
      in_data = 32'h0000_000C; out0_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fullpop_refuse: got ready=%b expected 0", in_ready);
      end
      cyc();
      n_tests++;
      if (out0_count !== CW'(1) || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fullpop_after: got count=%0d ready=%b expected count=1 ready=1",
                  out0_count, in_ready);
      end
      exp0.push_back(in_data);
      cyc();
      in_valid = 1'b0;
      n_tests++;
      if (out0_count !== CW'(1) || out0_data !== 32'h0000_000C) begin
         n_fail++;
         $display("FAIL fullpop_order: got count=%0d d=%h expected count=1 d=0000000c",
                  out0_count, out0_data);
      end
      cyc();
      n_tests++;
      if (out0_count !== '0) begin
         n_fail++;
         $display("FAIL fullpop_drain: got %0d expected 0", out0_count);
      end
   endtask

   task automatic test_wrap();
      out1_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h5000_0000;
      exp1.push_back(in_data);
      cyc();
      out1_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 32'h5000_0000 + i;
         exp1.push_back(in_data);
         cyc();
         n_tests++;
         if (out1_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL wrap_count%0d: got %0d expected 1", i, out1_count);
         end
      end
      in_valid = 1'b0;
      cyc();
      n_tests++;
      if (out1_count !== '0) begin
         n_fail++;
         $display("FAIL wrap_drain: got %0d expected 0", out1_count);
      end
   endtask

   task automatic test_reset_mid();
      out0_ready = 1'b0; out1_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_sel  = i[0];
         in_data = 32'hEE00_0000 + i;
         cyc();
      end
      n_tests++;
      if (out0_count !== CW'(2) || out1_count !== CW'(2)) begin
         n_fail++;
         $display("FAIL midrst_filled: got %0d/%0d expected 2/2", out0_count, out1_count);
      end
      rst = 1'b1; in_sel = 1'b0; in_data = 32'hBAD0_BAD0;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      n_tests++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0 || out1_data !== '0 ||
          out0_count !== '0 || out1_count !== '0) begin
         n_fail++;
         $display("FAIL midrst_state: got v=%b%b d=%h/%h c=%0d/%0d expected all 0",
                  out0_valid, out1_valid, out0_data, out1_data, out0_count, out1_count);
      end
      in_sel = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready1: got %b expected 1", in_ready);
      end
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hC0DE_0001; out0_ready = 1'b1;
      exp0.push_back(in_data);
      cyc();
      in_valid = 1'b0;
      n_tests++;
      if (out0_valid !== 1'b1 || out0_data !== 32'hC0DE_0001) begin
         n_fail++;
         $display("FAIL midrst_first: got v=%b d=%h expected v=1 d=c0de0001",
                  out0_valid, out0_data);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_full_pop();
      test_wrap();
      test_reset_mid();
      cyc();
      n_tests++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d/%0d words undelivered expected 0/0",
                  exp0.size(), exp1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
